// File: rtl/ddr_sdram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ddr_sdram_responder                                        |
// | Description : Single-clock DDR SDRAM target model. Decodes the command   |
// |               bus, walks the power-up sequence, enforces tRP/tRCD/tMRD/  |
// |               tRFC, tracks open rows per bank and serves one 32-bit word |
// |               per burst from a small internal array. The first protocol  |
// |               error is latched in a sticky flag/code pair.               |
// | Ports       : clk133_p        - sole clock, rising edge                  |
// |               rst             - asynchronous reset, active low           |
// |               sd_CKE/sd_CS    - clock enable / chip select (active low)  |
// |               sd_RAS/CAS/WE   - command bits                             |
// |               sd_BA, sd_A     - bank and row/column/mode address         |
// |               wrData          - write word, sampled the cycle after WRITE|
// |               rdData/rdValid  - read word and its one-cycle strobe       |
// |               initDone        - power-up sequence complete               |
// |               violation/Code  - sticky error flag and first error code   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ddr_sdram_responder #(
   parameter int ROW_IDX = 2,
   parameter int COL_IDX = 2,
   parameter int TRP     = 2,
   parameter int TRCD    = 2,
   parameter int TMRD    = 2,
   parameter int TRFC    = 10
) (
   input  logic        clk133_p,
   input  logic        rst,
   input  logic        sd_CKE,
   input  logic        sd_CS,
   input  logic        sd_RAS,
   input  logic        sd_CAS,
   input  logic        sd_WE,
   input  logic [1:0]  sd_BA,
   input  logic [12:0] sd_A,
   input  logic [31:0] wrData,
   output logic [31:0] rdData,
   output logic        rdValid,
   output logic        initDone,
   output logic        violation,
   output logic [2:0]  violationCode
);

   // Timer width: wide enough for the longest programmed interval.
   localparam int c_TW    = $clog2(TRFC + TRP + TRCD + TMRD + 2);
   localparam int c_IW    = 2 + ROW_IDX + COL_IDX;
   localparam int c_DEPTH = 1 << c_IW;

   localparam logic [c_TW-1:0] c_T_ONE    = c_TW'(1);
   localparam logic [c_TW-1:0] c_TRP_M1   = c_TW'(TRP - 1);
   localparam logic [c_TW-1:0] c_TRP_AP   = c_TW'(TRP);
   localparam logic [c_TW-1:0] c_TRCD_M1  = c_TW'(TRCD - 1);
   localparam logic [c_TW-1:0] c_TMRD_M1  = c_TW'(TMRD - 1);
   localparam logic [c_TW-1:0] c_TRFC_M1  = c_TW'(TRFC - 1);

   localparam logic [2:0] c_CMD_NOP = 3'b111;
   localparam logic [2:0] c_CMD_ACT = 3'b011;
   localparam logic [2:0] c_CMD_RD  = 3'b101;
   localparam logic [2:0] c_CMD_WR  = 3'b100;
   localparam logic [2:0] c_CMD_PRE = 3'b010;
   localparam logic [2:0] c_CMD_REF = 3'b001;
   localparam logic [2:0] c_CMD_LMR = 3'b000;

   localparam logic [3:0] c_ST_WAIT_CKE  = 4'd0;
   localparam logic [3:0] c_ST_WAIT_PRE  = 4'd1;
   localparam logic [3:0] c_ST_WAIT_EMR  = 4'd2;
   localparam logic [3:0] c_ST_WAIT_MR   = 4'd3;
   localparam logic [3:0] c_ST_WAIT_PRE2 = 4'd4;
   localparam logic [3:0] c_ST_WAIT_REF1 = 4'd5;
   localparam logic [3:0] c_ST_WAIT_REF2 = 4'd6;
   localparam logic [3:0] c_ST_WAIT_TRFC = 4'd7;
   localparam logic [3:0] c_ST_READY     = 4'd8;

   logic [3:0]              r_state;
   logic [3:0]              w_state_nxt;
   logic [3:0]              w_seq_nxt;
   logic                    w_seq_ok;
   logic [c_TW-1:0]         r_tmrd;
   logic [c_TW-1:0]         r_trfc;

   logic                    w_cmd_vld;
   logic [2:0]              w_cmd;
   logic                    w_is_nop;
   logic                    w_ready;
   logic                    w_mode_ok;
   logic [2:0]              w_err_code;
   logic                    w_exec;
   logic                    w_exec_act;
   logic                    w_exec_rd;
   logic                    w_exec_wr;
   logic                    w_exec_pre;
   logic                    w_exec_ref;
   logic                    w_exec_lmr;

   logic [3:0]              w_open;
   logic [3:0][ROW_IDX-1:0] w_rows;
   logic [3:0]              w_trp_zero;
   logic [3:0]              w_trcd_zero;
   logic [c_IW-1:0]         w_idx;

   logic [31:0]             r_mem [0:c_DEPTH-1];
   logic                    r_wr_pend;
   logic [c_IW-1:0]         r_wr_idx;
   logic                    r_rd_v1;
   logic                    r_rd_v2;
   logic [c_IW-1:0]         r_rd_idx1;
   logic [c_IW-1:0]         r_rd_idx2;

   // Only some address bits carry meaning; fold the rest away.
   logic                    w_unused;
   assign w_unused = &{1'b0, sd_A};

   // Deselected or clock-disabled cycles look exactly like NOP.
   assign w_cmd_vld = sd_CKE && !sd_CS;
   assign w_cmd     = w_cmd_vld ? {sd_RAS, sd_CAS, sd_WE} : c_CMD_NOP;
   assign w_is_nop  = (w_cmd == c_CMD_NOP);
   assign w_mode_ok = (sd_A[6:4] == 3'b010) && (sd_A[2:0] == 3'b001);

   // The cycle tRFC expires after the second refresh already decodes as READY.
   assign w_ready   = (r_state == c_ST_READY) ||
                      ((r_state == c_ST_WAIT_TRFC) && (r_trfc == '0));
   assign initDone  = (r_state == c_ST_READY);

   assign w_idx     = {sd_BA, w_rows[sd_BA], sd_A[COL_IDX:1]};

   always_comb begin
      w_err_code  = 3'd0;
      w_seq_ok    = 1'b0;
      w_seq_nxt   = r_state;
      w_state_nxt = r_state;

      case (r_state)
         c_ST_WAIT_PRE: begin
            w_seq_ok  = (w_cmd == c_CMD_PRE) && sd_A[10];
            w_seq_nxt = c_ST_WAIT_EMR;
         end
         c_ST_WAIT_EMR: begin
            w_seq_ok  = (w_cmd == c_CMD_LMR) && (sd_BA == 2'b01);
            w_seq_nxt = c_ST_WAIT_MR;
         end
         c_ST_WAIT_MR: begin
            w_seq_ok  = (w_cmd == c_CMD_LMR) && (sd_BA == 2'b00) && w_mode_ok;
            w_seq_nxt = c_ST_WAIT_PRE2;
         end
         c_ST_WAIT_PRE2: begin
            w_seq_ok  = (w_cmd == c_CMD_PRE) && sd_A[10];
            w_seq_nxt = c_ST_WAIT_REF1;
         end
         c_ST_WAIT_REF1: begin
            w_seq_ok  = (w_cmd == c_CMD_REF);
            w_seq_nxt = c_ST_WAIT_REF2;
         end
         c_ST_WAIT_REF2: begin
            w_seq_ok  = (w_cmd == c_CMD_REF);
            w_seq_nxt = c_ST_WAIT_TRFC;
         end
         default: ;
      endcase

      if ((r_state == c_ST_WAIT_CKE) && sd_CKE) begin
         w_state_nxt = c_ST_WAIT_PRE;
      end
      if ((r_state == c_ST_WAIT_TRFC) && (r_trfc == '0)) begin
         w_state_nxt = c_ST_READY;
      end

      if (!w_is_nop) begin
         if (!w_ready) begin
            if (!w_seq_ok)            w_err_code = 3'd1;
            else if (r_trfc != '0)    w_err_code = 3'd5;
            else if (r_tmrd != '0)    w_err_code = 3'd4;
            else                      w_state_nxt = w_seq_nxt;
         end else if (r_trfc != '0) begin
            w_err_code = 3'd5;
         end else if (r_tmrd != '0) begin
            w_err_code = 3'd4;
         end else begin
            case (w_cmd)
               c_CMD_ACT: begin
                  if (w_open[sd_BA])           w_err_code = 3'd7;
                  else if (!w_trp_zero[sd_BA]) w_err_code = 3'd2;
               end
               c_CMD_RD, c_CMD_WR: begin
                  if (!w_open[sd_BA])           w_err_code = 3'd6;
                  else if (!w_trcd_zero[sd_BA]) w_err_code = 3'd3;
               end
               c_CMD_PRE: ;
               c_CMD_REF: begin
                  if (|w_open) w_err_code = 3'd1;
               end
               c_CMD_LMR: begin
                  if (|w_open)                             w_err_code = 3'd1;
                  else if ((sd_BA == 2'b00) && !w_mode_ok) w_err_code = 3'd1;
               end
               default: w_err_code = 3'd1;   // BURST STOP is not supported
            endcase
         end
      end
   end

   assign w_exec     = !w_is_nop && (w_err_code == 3'd0);
   assign w_exec_act = w_exec && (w_cmd == c_CMD_ACT);
   assign w_exec_rd  = w_exec && (w_cmd == c_CMD_RD);
   assign w_exec_wr  = w_exec && (w_cmd == c_CMD_WR);
   assign w_exec_pre = w_exec && (w_cmd == c_CMD_PRE);
   assign w_exec_ref = w_exec && (w_cmd == c_CMD_REF);
   assign w_exec_lmr = w_exec && (w_cmd == c_CMD_LMR);

   for (genvar b = 0; b < 4; b++) begin : g_bank
      logic               r_open;
      logic [ROW_IDX-1:0] r_row;
      logic [c_TW-1:0]    r_trp;
      logic [c_TW-1:0]    r_trcd;
      logic               w_hit;

      assign w_hit          = (sd_BA == 2'(b));
      assign w_open[b]      = r_open;
      assign w_rows[b]      = r_row;
      assign w_trp_zero[b]  = (r_trp == '0);
      assign w_trcd_zero[b] = (r_trcd == '0);

      always_ff @(posedge clk133_p or negedge rst) begin
         if (!rst) begin
            r_open <= 1'b0;
            r_row  <= '0;
            r_trp  <= '0;
            r_trcd <= '0;
         end else begin
            if (r_trp != '0)  r_trp  <= r_trp - c_T_ONE;
            if (r_trcd != '0) r_trcd <= r_trcd - c_T_ONE;
            if (w_exec_act && w_hit) begin
               r_open <= 1'b1;
               r_row  <= sd_A[ROW_IDX-1:0];
               r_trcd <= c_TRCD_M1;
            end
            if (w_exec_pre && (sd_A[10] || w_hit)) begin
               r_open <= 1'b0;
               r_trp  <= c_TRP_M1;
            end
            // Auto-precharge: the implicit precharge lands one cycle after
            // the access, so the count is one longer than an explicit PRE.
            if ((w_exec_rd || w_exec_wr) && w_hit && sd_A[10]) begin
               r_open <= 1'b0;
               r_trp  <= c_TRP_AP;
            end
         end
      end
   end

   always_ff @(posedge clk133_p or negedge rst) begin
      if (!rst) begin
         r_state       <= c_ST_WAIT_CKE;
         r_tmrd        <= '0;
         r_trfc        <= '0;
         violation     <= 1'b0;
         violationCode <= 3'd0;
         r_wr_pend     <= 1'b0;
         r_wr_idx      <= '0;
         r_rd_v1       <= 1'b0;
         r_rd_v2       <= 1'b0;
         r_rd_idx1     <= '0;
         r_rd_idx2     <= '0;
         rdValid       <= 1'b0;
         rdData        <= 32'd0;
      end else begin
         r_state <= w_state_nxt;

         if (r_tmrd != '0) r_tmrd <= r_tmrd - c_T_ONE;
         if (w_exec_lmr)   r_tmrd <= c_TMRD_M1;
         if (r_trfc != '0) r_trfc <= r_trfc - c_T_ONE;
         if (w_exec_ref)   r_trfc <= c_TRFC_M1;

         if ((w_err_code != 3'd0) && !violation) begin
            violation     <= 1'b1;
            violationCode <= w_err_code;
         end

         r_wr_pend <= w_exec_wr;
         if (w_exec_wr) r_wr_idx <= w_idx;

         // Array is read two edges after READ; a WRITE one cycle ahead of the
         // READ has already committed by then, which gives write-first order.
         r_rd_v1 <= w_exec_rd;
         if (w_exec_rd) r_rd_idx1 <= w_idx;
         r_rd_v2   <= r_rd_v1;
         r_rd_idx2 <= r_rd_idx1;
         rdValid   <= r_rd_v2;
         if (r_rd_v2) rdData <= r_mem[r_rd_idx2];
      end
   end

   // Storage is intentionally not cleared by reset.
   always_ff @(posedge clk133_p) begin
      if (r_wr_pend) r_mem[r_wr_idx] <= wrData;
   end

endmodule
`default_nettype wire

// File: tb/tb_ddr_sdram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ddr_sdram_responder                                     |
// | Description : Directed scenarios plus randomized command traffic for     |
// |               ddr_sdram_responder, compared cycle by cycle against a     |
// |               timestamp-based behavioural model of the SDRAM rules.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ddr_sdram_responder;

   localparam int TRP  = 2;
   localparam int TRCD = 2;
   localparam int TMRD = 2;
   localparam int TRFC = 10;

   localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD  = 3'b101,
                          WR  = 3'b100, PRE = 3'b010, REF = 3'b001,
                          LMR = 3'b000, BST = 3'b110;

   logic        clk, rst, cke, cs, ras, cas, we;
   logic [1:0]  ba;
   logic [12:0] a;
   logic [31:0] wd;
   logic [31:0] rdData;
   logic        rdValid, initDone, violation;
   logic [2:0]  violationCode;

   int n_total = 0;
   int n_bad   = 0;

   ddr_sdram_responder dut (
      .clk133_p      (clk),
      .rst           (rst),
      .sd_CKE        (cke),
      .sd_CS         (cs),
      .sd_RAS        (ras),
      .sd_CAS        (cas),
      .sd_WE         (we),
      .sd_BA         (ba),
      .sd_A          (a),
      .wrData        (wd),
      .rdData        (rdData),
      .rdValid       (rdValid),
      .initDone      (initDone),
      .violation     (violation),
      .violationCode (violationCode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model (event timestamps) ----------------
   int          now;
   int          step;            // 0..7 init progress, 8 = ready
   bit          b_open [4];
   int          b_row  [4];
   int          t_pre  [4];      // cycle from which tRP is measured
   int          t_act  [4];
   int          t_lmr, t_ref;
   bit          m_viol;
   int          m_code;
   logic [31:0] mem_m  [64];
   bit          known  [64];
   bit          wp;
   int          wp_idx;
   int          rq_due [$];
   int          rq_idx [$];
   bit          e_valid;
   logic [31:0] e_data;
   bit          e_known;

   task automatic reset_model();
      now = 0; step = 0;
      for (int i = 0; i < 4; i++) begin
         b_open[i] = 0; b_row[i] = 0; t_pre[i] = -1000; t_act[i] = -1000;
      end
      t_lmr = -1000; t_ref = -1000;
      m_viol = 0; m_code = 0; wp = 0; wp_idx = 0;
      rq_due.delete(); rq_idx.delete();
      e_valid = 0; e_data = 32'd0; e_known = 1;
   endtask

   task automatic step_model();
      logic [2:0] c;
      int code, idx, i;
      bit ok, mode_ok, any_open;
      now++;
      e_valid = 0;
      if (rq_due.size() > 0 && rq_due[0] == now) begin
         i = rq_idx[0];
         rq_due.delete(0); rq_idx.delete(0);
         e_valid = 1; e_known = known[i]; e_data = mem_m[i];
      end
      if (wp) begin
         mem_m[wp_idx] = wd; known[wp_idx] = 1; wp = 0;
      end
      if (step == 7 && now - t_ref >= TRFC) step = 8;

      c = (cke && !cs) ? {ras, cas, we} : NOP;
      mode_ok  = (a[6:4] == 3'b010) && (a[2:0] == 3'b001);
      any_open = b_open[0] | b_open[1] | b_open[2] | b_open[3];
      code = 0;
      if (c != NOP) begin
         if (step != 8) begin
            case (step)
               1, 4:    ok = (c == PRE) && a[10];
               2:       ok = (c == LMR) && (ba == 2'd1);
               3:       ok = (c == LMR) && (ba == 2'd0) && mode_ok;
               5, 6:    ok = (c == REF);
               default: ok = 0;
            endcase
            if (!ok)                     code = 1;
            else if (now - t_ref < TRFC) code = 5;
            else if (now - t_lmr < TMRD) code = 4;
            else                         step++;
         end else if (now - t_ref < TRFC) code = 5;
         else if (now - t_lmr < TMRD)     code = 4;
         else begin
            case (c)
               ACT:     code = b_open[ba] ? 7 : ((now - t_pre[ba] < TRP) ? 2 : 0);
               RD, WR:  code = !b_open[ba] ? 6 : ((now - t_act[ba] < TRCD) ? 3 : 0);
               PRE:     code = 0;
               REF:     code = any_open ? 1 : 0;
               LMR:     code = (any_open || (ba == 2'd0 && !mode_ok)) ? 1 : 0;
               default: code = 1;
            endcase
         end
         if (code == 0) begin
            case (c)
               ACT: begin b_open[ba] = 1; b_row[ba] = int'(a[1:0]); t_act[ba] = now; end
               RD, WR: begin
                  idx = int'(ba) * 16 + b_row[ba] * 4 + int'(a[2:1]);
                  if (c == RD) begin rq_due.push_back(now + 2); rq_idx.push_back(idx); end
                  else begin wp = 1; wp_idx = idx; end
                  if (a[10]) begin b_open[ba] = 0; t_pre[ba] = now + 1; end
               end
               PRE: for (int k = 0; k < 4; k++)
                       if (a[10] || int'(ba) == k) begin b_open[k] = 0; t_pre[k] = now; end
               REF: t_ref = now;
               LMR: t_lmr = now;
               default: ;
            endcase
         end else if (!m_viol) begin
            m_viol = 1; m_code = code;
         end
      end
      if (step == 0 && cke) step = 1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic k, input logic s, input logic [2:0] c,
                      input logic [1:0] b, input logic [12:0] ad, input logic [31:0] d);
      cke = k; cs = s; {ras, cas, we} = c; ba = b; a = ad; wd = d;
      @(posedge clk);
      #1;
      step_model();
      chk("rdValid", 32'(rdValid), 32'(e_valid));
      if (e_known) chk("rdData", rdData, e_data);
      chk("violation", 32'(violation), 32'(m_viol));
      chk("violationCode", 32'(violationCode), 32'(m_code));
      chk("initDone", 32'(initDone), 32'(step == 8));
   endtask

   task automatic cmd(input logic [2:0] c, input logic [1:0] b,
                      input logic [12:0] ad, input logic [31:0] d);
      cyc(1'b1, 1'b0, c, b, ad, d);
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) cmd(NOP, 2'd0, 13'd0, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0; cke = 1'b0; cs = 1'b1; {ras, cas, we} = NOP;
      ba = 2'd0; a = 13'd0; wd = 32'd0;
      #1;
      chk("rst_rdValid", 32'(rdValid), 32'd0);
      chk("rst_rdData", rdData, 32'd0);
      chk("rst_initDone", 32'(initDone), 32'd0);
      chk("rst_violation", 32'(violation), 32'd0);
      chk("rst_code", 32'(violationCode), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      reset_model();
   endtask

   task automatic do_init();
      cyc(1'b0, 1'b1, NOP, 2'd0, 13'd0, 32'd0);
      nop(1);
      cmd(PRE, 2'd0, 13'h400, 32'd0); nop(1);
      cmd(LMR, 2'd1, 13'h000, 32'd0); nop(1);
      cmd(LMR, 2'd0, 13'h021, 32'd0); nop(1);
      cmd(PRE, 2'd0, 13'h400, 32'd0); nop(1);
      cmd(REF, 2'd0, 13'd0, 32'd0);   nop(10);
      cmd(REF, 2'd0, 13'd0, 32'd0);   nop(9);
      chk("init_not_yet", 32'(initDone), 32'd0);
      nop(1);
      chk("init_done", 32'(initDone), 32'd1);
      chk("init_no_viol", 32'(violation), 32'd0);
   endtask

   int          r;
   logic [1:0]  rb;
   logic [12:0] ra;

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 64; i++) begin mem_m[i] = 32'd0; known[i] = 0; end
      reset_model();

      // Write then read back through bank 1, row 3, column 4.
      do_reset(); do_init();
      cmd(ACT, 2'd1, 13'd3, 32'd0); nop(2);
      cmd(WR, 2'd1, 13'd4, 32'd0);
      cmd(NOP, 2'd0, 13'd0, 32'hF0F00F0F);
      cmd(RD, 2'd1, 13'd4, 32'd0);
      nop(1);
      chk("wr_rd_early", 32'(rdValid), 32'd0);
      nop(1);
      chk("wr_rd_valid", 32'(rdValid), 32'd1);
      chk("wr_rd_data", rdData, 32'hF0F00F0F);

      // ACT then READ one cycle later violates tRCD.
      do_reset(); do_init();
      cmd(ACT, 2'd0, 13'd0, 32'd0);
      cmd(RD, 2'd0, 13'd0, 32'd0);
      chk("trcd_flag", 32'(violation), 32'd1);
      chk("trcd_code", 32'(violationCode), 32'd3);
      nop(2);
      chk("trcd_no_read", 32'(rdValid), 32'd0);

      // Bad mode register (CL3) during init.
      do_reset();
      cyc(1'b0, 1'b1, NOP, 2'd0, 13'd0, 32'd0);
      nop(1);
      cmd(PRE, 2'd0, 13'h400, 32'd0); nop(1);
      cmd(LMR, 2'd1, 13'h000, 32'd0); nop(1);
      cmd(LMR, 2'd0, 13'h031, 32'd0);
      chk("cl3_code", 32'(violationCode), 32'd1);
      nop(3);
      chk("cl3_no_init", 32'(initDone), 32'd0);

      // tRFC violation, then a later error leaves the code untouched.
      do_reset(); do_init();
      cmd(REF, 2'd0, 13'd0, 32'd0); nop(4);
      cmd(ACT, 2'd0, 13'd0, 32'd0);
      chk("trfc_code", 32'(violationCode), 32'd5);
      nop(10);
      cmd(RD, 2'd2, 13'd0, 32'd0);
      chk("sticky_code", 32'(violationCode), 32'd5);
      chk("sticky_flag", 32'(violation), 32'd1);

      // Back-to-back reads, then reset while a read is outstanding.
      do_reset(); do_init();
      cmd(ACT, 2'd2, 13'd1, 32'd0); nop(1);
      cmd(WR, 2'd2, 13'd0, 32'd0);
      cmd(WR, 2'd2, 13'd2, 32'h1234_5678);
      cmd(NOP, 2'd0, 13'd0, 32'hCAFE_BABE);
      cmd(RD, 2'd2, 13'd0, 32'd0);
      cmd(RD, 2'd2, 13'd2, 32'd0);
      nop(1);
      chk("b2b_v1", 32'(rdValid), 32'd1);
      chk("b2b_d1", rdData, 32'h1234_5678);
      nop(1);
      chk("b2b_v2", 32'(rdValid), 32'd1);
      chk("b2b_d2", rdData, 32'hCAFE_BABE);
      nop(1);
      chk("b2b_hold", rdData, 32'hCAFE_BABE);
      cmd(RD, 2'd2, 13'd0, 32'd0);
      cmd(RD, 2'd2, 13'd2, 32'd0);
      nop(1);
      chk("pre_rst_valid", 32'(rdValid), 32'd1);
      do_reset();
      nop(3);

      // Randomized traffic after a clean init.
      for (int rnd = 0; rnd < 4; rnd++) begin
         do_reset(); do_init();
         for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 99);
            rb = 2'($urandom_range(0, 3));
            ra = 13'($urandom);
            ra[10] = ($urandom_range(0, 4) == 0);
            if (r < 35)      cmd(NOP, rb, ra, $urandom);
            else if (r < 49) cmd(ACT, rb, ra, $urandom);
            else if (r < 63) cmd(RD,  rb, ra, $urandom);
            else if (r < 77) cmd(WR,  rb, ra, $urandom);
            else if (r < 87) begin
               ra[10] = ($urandom_range(0, 1) == 1);
               cmd(PRE, rb, ra, $urandom);
            end
            else if (r < 90) cmd(REF, rb, ra, $urandom);
            else if (r < 93) begin
               if ($urandom_range(0, 1) == 1) ra = 13'h021;
               cmd(LMR, rb, ra, $urandom);
            end
            else if (r < 94) cmd(BST, rb, ra, $urandom);
            else if (r < 97) cyc(1'b1, 1'b1, 3'($urandom), rb, ra, $urandom);
            else             cyc(1'b0, 1'b0, 3'($urandom), rb, ra, $urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
